// File: rtl/prt_dp_pkg.sv
// ---------------------------------------------------------------------------
// prt_dp_pkg
// Shared definitions for the DP RX message path blocks.
//   state_e     : message arbiter FSM states
//   CNT_W       : width of the message stall counter
//   TERM_FLAGS  : SOM/EOM flags of the word injected to close a stalled
//                 message (its data field is all zeros)
// ---------------------------------------------------------------------------
package prt_dp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } state_e;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic som;
    logic eom;
  } msg_flags_t;

  // Terminator closes the message without opening a new one.
  localparam msg_flags_t TERM_FLAGS = '{som: 1'b0, eom: 1'b1};

endpackage

// File: rtl/prt_dp_lib_rr_sel.sv
// ---------------------------------------------------------------------------
// prt_dp_lib_rr_sel
// Combinational round-robin picker. Searches the request vector starting at
// last_i+1 and wrapping modulo P_REQ; the first set bit wins.
//   req_i   : request vector
//   last_i  : index of the most recently served requester
//   pick_o  : one-hot winner (0 when nothing requests)
//   any_o   : at least one request present
// ---------------------------------------------------------------------------
module prt_dp_lib_rr_sel #(
  parameter int P_REQ = 4,
  parameter int IDX_W = (P_REQ > 1) ? $clog2(P_REQ) : 1
) (
  input  logic [P_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [P_REQ-1:0] pick_o,
  output logic             any_o
);

  always_comb begin
    int idx;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves it unassigned infers a latch.
    pick_o = '0;
    any_o  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= P_REQ; k++) begin
      idx = (int'(last_i) + k) % P_REQ;
      if (!any_o && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prt_dprx_msg_arb.sv
// ---------------------------------------------------------------------------
// prt_dprx_msg_arb
// Packet-atomic round-robin arbiter sharing the message path into the policy
// maker between the DP RX link sub-blocks. One requester is granted per
// complete message; words pass through a single registered output stage.
// A stall watchdog closes an abandoned message with a terminator word.
//
// Ports
//   CLK_IN, RST_IN           : clock, synchronous active-high reset
//   REQ_VLD/SOM/EOM/DAT_IN   : per-requester word, data packed r*P_DAT
//   REQ_RDY_OUT              : per-requester ready (combinational)
//   OUT_VLD/SOM/EOM/DAT_OUT  : registered output word
//   OUT_RDY_IN               : downstream ready
//   STA_GNT_OUT              : one-hot current grant, 0 when idle
//   STA_TO_OUT               : pulse when a stalled message is aborted
//   STA_ERR_OUT              : pulse when an orphan word is discarded
// ---------------------------------------------------------------------------
module prt_dprx_msg_arb
  import prt_dp_pkg::*;
#(
  parameter int P_REQ = 4,
  parameter int P_DAT = 16,
  parameter int P_TO  = 255
) (
  input  logic                   CLK_IN,
  input  logic                   RST_IN,
  input  logic [P_REQ-1:0]       REQ_VLD_IN,
  input  logic [P_REQ-1:0]       REQ_SOM_IN,
  input  logic [P_REQ-1:0]       REQ_EOM_IN,
  input  logic [P_REQ*P_DAT-1:0] REQ_DAT_IN,
  output logic [P_REQ-1:0]       REQ_RDY_OUT,
  output logic                   OUT_VLD_OUT,
  output logic                   OUT_SOM_OUT,
  output logic                   OUT_EOM_OUT,
  output logic [P_DAT-1:0]       OUT_DAT_OUT,
  input  logic                   OUT_RDY_IN,
  output logic [P_REQ-1:0]       STA_GNT_OUT,
  output logic                   STA_TO_OUT,
  output logic                   STA_ERR_OUT
);

  localparam int               IDX_W  = (P_REQ > 1) ? $clog2(P_REQ) : 1;
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(P_TO);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(P_REQ - 1);

  state_e             state_q,   state_d;
  logic [IDX_W-1:0]   last_q,    last_d;
  logic [P_REQ-1:0]   gnt_q,     gnt_d;
  logic [IDX_W-1:0]   gidx_q,    gidx_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               out_vld_q, out_vld_d;
  logic               out_som_q, out_som_d;
  logic               out_eom_q, out_eom_d;
  logic [P_DAT-1:0]   out_dat_q, out_dat_d;
  logic               sta_to_q,  sta_to_d;
  logic               sta_err_q, sta_err_d;

  logic [P_REQ-1:0]   cand;
  logic [P_REQ-1:0]   orphan;
  logic [P_REQ-1:0]   pick;
  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic               out_free;
  logic               g_vld;
  logic               g_eom;
  logic               g_som;
  logic [P_DAT-1:0]   g_dat;
  logic               g_xfer;

  assign cand     = REQ_VLD_IN & REQ_SOM_IN;
  assign orphan   = REQ_VLD_IN & ~REQ_SOM_IN;
  assign out_free = ~out_vld_q | OUT_RDY_IN;

  assign g_vld = REQ_VLD_IN[gidx_q];
  assign g_som = REQ_SOM_IN[gidx_q];
  assign g_eom = REQ_EOM_IN[gidx_q];
  assign g_dat = REQ_DAT_IN[gidx_q*P_DAT +: P_DAT];

  prt_dp_lib_rr_sel #(
    .P_REQ (P_REQ),
    .IDX_W (IDX_W)
  ) u_rr_sel (
    .req_i  (cand),
    .last_i (last_q),
    .pick_o (pick),
    .any_o  (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int r = 0; r < P_REQ; r++) begin
      if (pick[r]) pick_idx = IDX_W'(r);
    end
  end

  // Ready is held low while reset is asserted so no requester believes a
  // word was taken that reset is about to discard.
  always_comb begin
    REQ_RDY_OUT = '0;
    if (!RST_IN) begin
      unique case (state_q)
        ST_IDLE: REQ_RDY_OUT = orphan;
        ST_BUSY: REQ_RDY_OUT = gnt_q & {P_REQ{out_free}};
        default: REQ_RDY_OUT = '0;
      endcase
    end
  end

  assign g_xfer = (state_q == ST_BUSY) && g_vld && out_free;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    gidx_d    = gidx_q;
    cnt_d     = cnt_q;
    out_vld_d = out_vld_q & ~OUT_RDY_IN;
    out_som_d = out_som_q;
    out_eom_d = out_eom_q;
    out_dat_d = out_dat_q;
    sta_to_d  = 1'b0;
    sta_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        sta_err_d = |orphan;
        if (pick_any) begin
          gnt_d   = pick;
          gidx_d  = pick_idx;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        // A transfer always clears the watchdog, so it wins over a timeout
        // that would otherwise fire in the same cycle.
        if (g_xfer) begin
          out_vld_d = 1'b1;
          out_som_d = g_som;
          out_eom_d = g_eom;
          out_dat_d = g_dat;
          cnt_d     = '0;
          if (g_eom) begin
            last_d  = gidx_q;
            gnt_d   = '0;
            state_d = ST_IDLE;
          end
        end else if (!g_vld) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == TO_LIM) state_d = ST_ABORT;
        end
      end

      ST_ABORT: begin
        if (out_free) begin
          out_vld_d = 1'b1;
          out_som_d = TERM_FLAGS.som;
          out_eom_d = TERM_FLAGS.eom;
          out_dat_d = '0;
          sta_to_d  = 1'b1;
          last_d    = gidx_q;
          gnt_d     = '0;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge value of every other; blocking here would create
  // order-dependent simulation results.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      state_q   <= ST_IDLE;
      last_q    <= LAST_RST;
      gnt_q     <= '0;
      gidx_q    <= '0;
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
      out_som_q <= 1'b0;
      out_eom_q <= 1'b0;
      // NOTE: the data register is reset too because the output port must
      // read 0 after reset; pure data storage would normally skip reset.
      out_dat_q <= '0;
      sta_to_q  <= 1'b0;
      sta_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      gidx_q    <= gidx_d;
      cnt_q     <= cnt_d;
      out_vld_q <= out_vld_d;
      out_som_q <= out_som_d;
      out_eom_q <= out_eom_d;
      out_dat_q <= out_dat_d;
      sta_to_q  <= sta_to_d;
      sta_err_q <= sta_err_d;
    end
  end

  assign OUT_VLD_OUT = out_vld_q;
  assign OUT_SOM_OUT = out_som_q;
  assign OUT_EOM_OUT = out_eom_q;
  assign OUT_DAT_OUT = out_dat_q;
  assign STA_GNT_OUT = gnt_q;
  assign STA_TO_OUT  = sta_to_q;
  assign STA_ERR_OUT = sta_err_q;

endmodule

// File: tb/tb_prt_dprx_msg_arb.sv
// ---------------------------------------------------------------------------
// tb_prt_dprx_msg_arb
// Directed scenarios followed by a saturated random phase. Each requester is
// modelled as a queue of words it offers; a word leaves the queue when it is
// accepted. In the random phase every requester always has a message pending,
// so round-robin fairness fixes the output order: message k of requester 0,
// then 1, 2, 3, then message k+1 of requester 0, and so on.
// ---------------------------------------------------------------------------
module tb_prt_dprx_msg_arb;

  localparam int NR   = 4;
  localparam int DW   = 16;
  localparam int TO   = 10;
  localparam int LOGN = 4096;

  typedef struct {
    logic          som;
    logic          eom;
    logic [DW-1:0] dat;
    int            gap;
  } word_t;

  logic             clk = 1'b0;
  logic             RST_IN;
  logic [NR-1:0]    REQ_VLD_IN, REQ_SOM_IN, REQ_EOM_IN, REQ_RDY_OUT;
  logic [NR*DW-1:0] REQ_DAT_IN;
  logic             OUT_VLD_OUT, OUT_SOM_OUT, OUT_EOM_OUT, OUT_RDY_IN;
  logic [DW-1:0]    OUT_DAT_OUT;
  logic [NR-1:0]    STA_GNT_OUT;
  logic             STA_TO_OUT, STA_ERR_OUT;

  always #5 clk = ~clk;

  prt_dprx_msg_arb #(.P_REQ(NR), .P_DAT(DW), .P_TO(TO)) dut (
    .CLK_IN      (clk),
    .RST_IN      (RST_IN),
    .REQ_VLD_IN  (REQ_VLD_IN),
    .REQ_SOM_IN  (REQ_SOM_IN),
    .REQ_EOM_IN  (REQ_EOM_IN),
    .REQ_DAT_IN  (REQ_DAT_IN),
    .REQ_RDY_OUT (REQ_RDY_OUT),
    .OUT_VLD_OUT (OUT_VLD_OUT),
    .OUT_SOM_OUT (OUT_SOM_OUT),
    .OUT_EOM_OUT (OUT_EOM_OUT),
    .OUT_DAT_OUT (OUT_DAT_OUT),
    .OUT_RDY_IN  (OUT_RDY_IN),
    .STA_GNT_OUT (STA_GNT_OUT),
    .STA_TO_OUT  (STA_TO_OUT),
    .STA_ERR_OUT (STA_ERR_OUT)
  );

  word_t q[NR][$];
  word_t exp_q[$];

  logic          lg_vld [LOGN];
  logic          lg_som [LOGN];
  logic          lg_eom [LOGN];
  logic [DW-1:0] lg_dat [LOGN];
  logic          lg_hs  [LOGN];
  logic [NR-1:0] lg_gnt [LOGN];
  logic [NR-1:0] lg_rdy [LOGN];
  logic          lg_to  [LOGN];
  logic          lg_err [LOGN];

  int   cnum = 0;
  logic rst_drv = 1'b1;
  logic ordy_drv = 1'b1;
  bit   sb_on = 1'b0;
  int   checks = 0, failures = 0;
  int   to_seen = 0, err_seen = 0, bad_gnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    RST_IN     = rst_drv;
    OUT_RDY_IN = ordy_drv;
    REQ_VLD_IN = '0;
    REQ_SOM_IN = '0;
    REQ_EOM_IN = '0;
    REQ_DAT_IN = '0;
    for (int r = 0; r < NR; r++) begin
      if (q[r].size() > 0 && q[r][0].gap == 0) begin
        REQ_VLD_IN[r]          = 1'b1;
        REQ_SOM_IN[r]          = q[r][0].som;
        REQ_EOM_IN[r]          = q[r][0].eom;
        REQ_DAT_IN[r*DW +: DW] = q[r][0].dat;
      end
    end
  endtask

  // One clock cycle: drive, sample on the falling edge, retire accepted words.
  task automatic cyc();
    word_t w;
    drive();
    @(negedge clk);
    if (cnum < LOGN) begin
      lg_vld[cnum] = OUT_VLD_OUT;
      lg_som[cnum] = OUT_SOM_OUT;
      lg_eom[cnum] = OUT_EOM_OUT;
      lg_dat[cnum] = OUT_DAT_OUT;
      lg_hs[cnum]  = OUT_VLD_OUT & OUT_RDY_IN;
      lg_gnt[cnum] = STA_GNT_OUT;
      lg_rdy[cnum] = REQ_RDY_OUT;
      lg_to[cnum]  = STA_TO_OUT;
      lg_err[cnum] = STA_ERR_OUT;
    end
    if (sb_on && OUT_VLD_OUT && OUT_RDY_IN) begin
      if (exp_q.size() == 0) begin
        check("sb_extra_word", 64'(OUT_DAT_OUT), 64'hDEAD_0000_0000);
      end else begin
        w = exp_q.pop_front();
        check("sb_word", {OUT_SOM_OUT, OUT_EOM_OUT, OUT_DAT_OUT}, {w.som, w.eom, w.dat});
      end
    end
    if (STA_TO_OUT)  to_seen++;
    if (STA_ERR_OUT) err_seen++;
    if (!$onehot0(STA_GNT_OUT)) bad_gnt++;
    for (int r = 0; r < NR; r++) begin
      if (q[r].size() > 0) begin
        if (REQ_VLD_IN[r] && REQ_RDY_OUT[r]) begin
          q[r].delete(0);
        end else if (q[r][0].gap > 0) begin
          w = q[r][0];
          w.gap--;
          q[r][0] = w;
        end
      end
    end
    @(posedge clk);
    #1;
    cnum++;
  endtask

  task automatic flush();
    for (int r = 0; r < NR; r++) q[r].delete();
  endtask

  task automatic do_reset();
    flush();
    rst_drv = 1'b1;
    cyc();
    cyc();
    rst_drv = 1'b0;
  endtask

  task automatic push_word(input int r, input logic som, input logic eom, input logic [DW-1:0] dat);
    word_t w;
    w.som = som; w.eom = eom; w.dat = dat; w.gap = 0;
    q[r].push_back(w);
  endtask

  task automatic push_msg(input int r, input int len, input logic [DW-1:0] base,
                          input int maxgap, input bit to_sb);
    word_t w;
    for (int i = 0; i < len; i++) begin
      w.som = (i == 0);
      w.eom = (i == len - 1);
      w.dat = base + DW'(i);
      w.gap = (i == 0) ? 0 : int'($urandom_range(0, maxgap));
      q[r].push_back(w);
      if (to_sb) exp_q.push_back(w);
    end
  endtask

  initial begin
    int b;
    int n;
    int hs_n;
    logic [DW-1:0] hs_dat [4];

    // ---- reset state --------------------------------------------------
    do_reset();
    drive();
    #1;
    check("rst_out_vld", OUT_VLD_OUT, 1'b0);
    check("rst_out_bus", {OUT_SOM_OUT, OUT_EOM_OUT, OUT_DAT_OUT}, '0);
    check("rst_gnt", STA_GNT_OUT, 4'b0000);
    check("rst_rdy", REQ_RDY_OUT, 4'b0000);
    check("rst_sta", {STA_TO_OUT, STA_ERR_OUT}, 2'b00);

    // ---- two simultaneous 3-word messages: req0 first, then req2 ------
    ordy_drv = 1'b1;
    push_msg(0, 3, 16'hA001, 0, 1'b0);
    push_msg(2, 3, 16'hC001, 0, 1'b0);
    b = cnum;
    repeat (10) cyc();
    for (int i = 0; i < 10; i++) begin
      check("t1_vld", lg_vld[b+i], (i >= 2 && i <= 4) || (i >= 6 && i <= 8));
      check("t1_gnt", lg_gnt[b+i], (i >= 1 && i <= 3) ? 4'b0001 :
                                   (i >= 5 && i <= 7) ? 4'b0100 : 4'b0000);
    end
    for (int i = 0; i < 3; i++) begin
      check("t1_dat_a", lg_dat[b+2+i], 16'hA001 + DW'(i));
      check("t1_dat_c", lg_dat[b+6+i], 16'hC001 + DW'(i));
    end
    check("t1_flags_first", {lg_som[b+2], lg_eom[b+2]}, 2'b10);
    check("t1_flags_last",  {lg_som[b+8], lg_eom[b+8]}, 2'b01);

    // ---- all four present single-word messages: order 0,1,2,3,0,1,2,3 -
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < NR; r++)
        push_msg(r, 1, DW'(16'h0100 * r + k), 0, 1'b0);
    b = cnum;
    repeat (18) cyc();
    for (int j = 0; j < 8; j++) begin
      check("t2_gnt", lg_gnt[b+1+2*j], 4'b0001 << (j % 4));
      check("t2_dat", {lg_vld[b+2+2*j], lg_dat[b+2+2*j]},
            {1'b1, DW'(16'h0100 * (j % 4) + j / 4)});
    end

    // ---- downstream stall of 5 cycles mid-message ---------------------
    do_reset();
    push_msg(0, 4, 16'hB001, 0, 1'b0);
    b = cnum;
    cyc();
    cyc();
    ordy_drv = 1'b0;
    repeat (5) cyc();
    ordy_drv = 1'b1;
    repeat (6) cyc();
    for (int i = 2; i <= 6; i++) begin
      check("t3_hold", {lg_vld[b+i], lg_som[b+i], lg_dat[b+i]}, {2'b11, 16'hB001});
      check("t3_rdy_low", lg_rdy[b+i], 4'b0000);
      check("t3_gnt", lg_gnt[b+i], 4'b0001);
    end
    hs_n = 0;
    for (int i = 0; i < 13; i++) begin
      if (lg_hs[b+i]) begin
        if (hs_n < 4) hs_dat[hs_n] = lg_dat[b+i];
        hs_n++;
      end
    end
    check("t3_word_count", hs_n, 4);
    for (int i = 0; i < 4; i++)
      if (i < hs_n) check("t3_word", hs_dat[i], 16'hB001 + DW'(i));

    // ---- stalled message from req1 aborted after TO idle cycles --------
    do_reset();
    push_word(1, 1'b1, 1'b0, 16'hD001);
    b = cnum;
    repeat (16) cyc();
    for (int i = 1; i <= 12; i++) check("t4_gnt", lg_gnt[b+i], 4'b0010);
    check("t4_gnt_released", lg_gnt[b+13], 4'b0000);
    check("t4_abort_rdy", lg_rdy[b+12], 4'b0000);
    check("t4_to_before", lg_to[b+12], 1'b0);
    check("t4_to_pulse", lg_to[b+13], 1'b1);
    check("t4_term_word", {lg_vld[b+13], lg_som[b+13], lg_eom[b+13], lg_dat[b+13]},
          {3'b101, 16'h0000});
    n = 0;
    for (int i = 0; i < 16; i++) if (lg_to[b+i]) n++;
    check("t4_to_once", n, 1);

    // ---- orphan word from req3 while idle ------------------------------
    do_reset();
    push_word(3, 1'b0, 1'b0, 16'h0BAD);
    b = cnum;
    repeat (4) cyc();
    check("t5_orphan_rdy", lg_rdy[b], 4'b1000);
    check("t5_err_pre", lg_err[b], 1'b0);
    check("t5_err_pulse", lg_err[b+1], 1'b1);
    check("t5_err_post", lg_err[b+2], 1'b0);
    check("t5_dropped", q[3].size(), 0);
    for (int i = 0; i < 4; i++)
      check("t5_no_out", {lg_vld[b+i], lg_gnt[b+i]}, '0);

    // ---- reset in the middle of a message restores priority to req0 ----
    do_reset();
    push_msg(1, 1, 16'h1001, 0, 1'b0);
    repeat (3) cyc();
    push_msg(0, 4, 16'hE001, 0, 1'b0);
    b = cnum;
    cyc();
    cyc();
    flush();
    rst_drv = 1'b1;
    cyc();
    rst_drv = 1'b0;
    cyc();
    check("t6_pre_rst_out", {lg_vld[b+2], lg_dat[b+2]}, {1'b1, 16'hE001});
    check("t6_all_zero", {lg_vld[b+3], lg_som[b+3], lg_eom[b+3], lg_dat[b+3],
                          lg_gnt[b+3], lg_rdy[b+3], lg_to[b+3], lg_err[b+3]}, '0);
    push_msg(0, 1, 16'hF001, 0, 1'b0);
    push_msg(2, 1, 16'h2001, 0, 1'b0);
    repeat (3) cyc();
    check("t6_req0_first", lg_gnt[b+5], 4'b0001);
    check("t6_req0_word", {lg_vld[b+6], lg_dat[b+6]}, {1'b1, 16'hF001});

    // ---- saturated random traffic vs. round-robin reference ------------
    do_reset();
    exp_q.delete();
    for (int k = 0; k < 12; k++)
      for (int r = 0; r < NR; r++)
        push_msg(r, int'($urandom_range(1, 5)), DW'($urandom), 3, 1'b1);
    to_seen  = 0;
    err_seen = 0;
    bad_gnt  = 0;
    sb_on    = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 6000) begin
      ordy_drv = ($urandom_range(0, 3) != 0);
      cyc();
      n++;
    end
    sb_on    = 1'b0;
    ordy_drv = 1'b1;
    check("rnd_drained", exp_q.size(), 0);
    check("rnd_no_timeout", to_seen, 0);
    check("rnd_no_orphan", err_seen, 0);
    check("rnd_gnt_onehot0", bad_gnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
